// File: rtl/hdmi_aux_unpacker_pkg.sv
// Shared constants, slot-phase decode type and BCH helpers for the HDMI
// data-island aux receive path.
package hdmi_aux_unpacker_pkg;

    localparam int HDMI_AUX_SLOTS = 32;
    localparam int HDR_DATA_BITS  = 24;
    localparam int SUB_DATA_BITS  = 56;
    localparam int ECC_BITS       = 8;
    localparam int SLOT_W         = $clog2(HDMI_AUX_SLOTS);

    // Generator x^8+x^7+x^6+1, low-order coefficients (x^8 implied).
    localparam logic [ECC_BITS-1:0] BCH_POLY = 8'hC1;

    // Slot boundaries inside one 32-period packet.
    localparam logic [SLOT_W-1:0] HDR_PARITY_SLOT = 5'd24;
    localparam logic [SLOT_W-1:0] SUB_PARITY_SLOT = 5'd28;
    localparam logic [SLOT_W-1:0] LAST_SLOT       = 5'd31;

    // What the current registered period carries.
    typedef enum logic [1:0] {
        PH_IDLE       = 2'd0,  // no data island period
        PH_DATA       = 2'd1,  // header and subpackets both carry data
        PH_HDR_PARITY = 2'd2,  // header parity, subpackets still data
        PH_ALL_PARITY = 2'd3   // header and subpackets both parity
    } aux_phase_e;

    // One LFSR step. The register is kept bit-reversed with respect to the
    // textbook CRC, so the feedback mask is the reflected generator and the
    // next expected parity bit is always ecc[0].
    function automatic logic [ECC_BITS-1:0] bch_step(
        input logic [ECC_BITS-1:0] ecc,
        input logic                d
    );
        logic [ECC_BITS-1:0] mask;
        mask = {ECC_BITS{1'b0}};
        for (int i = 0; i < ECC_BITS; i++) begin
            mask[i] = BCH_POLY[ECC_BITS-1-i];
        end
        bch_step = {1'b0, ecc[ECC_BITS-1:1]} ^ ((ecc[0] ^ d) ? mask : {ECC_BITS{1'b0}});
    endfunction

    // Compare two received parity bits against the next two expected ones.
    function automatic logic bch_mismatch2(
        input logic [ECC_BITS-1:0] ecc,
        input logic                p0,
        input logic                p1
    );
        bch_mismatch2 = (p0 != ecc[0]) | (p1 != ecc[1]);
    endfunction

endpackage

// File: rtl/hdmi_aux_unpacker_if.sv
// Aux nibble input bundle and decoded packet output bundle.
interface hdmi_aux_unpacker_if;
    import hdmi_aux_unpacker_pkg::*;

    logic                     ae;
    logic [3:0]               channel0_aux;
    logic [3:0]               channel1_aux;
    logic [3:0]               channel2_aux;
    logic                     hsync_out;
    logic                     vsync_out;
    logic                     packet_valid;
    logic [HDR_DATA_BITS-1:0] header;
    logic [SUB_DATA_BITS-1:0] sub0;
    logic [SUB_DATA_BITS-1:0] sub1;
    logic [SUB_DATA_BITS-1:0] sub2;
    logic [SUB_DATA_BITS-1:0] sub3;
    logic                     header_err;
    logic [3:0]               sub_err;
    logic                     packet_abort;

    // Upstream side: TERC4 decoder / island detector and packet consumers.
    modport master (
        output ae, channel0_aux, channel1_aux, channel2_aux,
        input  hsync_out, vsync_out, packet_valid, header,
               sub0, sub1, sub2, sub3, header_err, sub_err, packet_abort
    );

    // Unpacker side.
    modport slave (
        input  ae, channel0_aux, channel1_aux, channel2_aux,
        output hsync_out, vsync_out, packet_valid, header,
               sub0, sub1, sub2, sub3, header_err, sub_err, packet_abort
    );
endinterface

// File: rtl/hdmi_aux_unpacker_sub_capture.sv
// One subpacket lane: 2-bit-per-slot data shift register plus the dual-bit
// BCH LFSR that checks the four parity slots. Instantiated once per lane.
module hdmi_aux_unpacker_sub_capture
    import hdmi_aux_unpacker_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,      // registered ae
    input  logic                     start,   // slot 0 of a packet
    input  logic                     parity,  // slots 28..31
    input  logic                     d1,      // even bit (channel 1)
    input  logic                     d2,      // odd bit (channel 2)
    output logic [SUB_DATA_BITS-1:0] data,
    output logic                     err
);

    logic [SUB_DATA_BITS-1:0] data_r;
    logic [SUB_DATA_BITS-1:0] data_nxt_s;
    logic [ECC_BITS-1:0]      lfsr_r;
    logic [ECC_BITS-1:0]      lfsr_base_s;
    logic [ECC_BITS-1:0]      lfsr_nxt_s;
    logic                     err_r;
    logic                     err_base_s;
    logic                     err_nxt_s;

    // Next-state for data shift, LFSR and sticky error; slot 0 restarts from zero.
    always_comb begin
        lfsr_base_s = start ? {ECC_BITS{1'b0}} : lfsr_r;
        err_base_s  = start ? 1'b0 : err_r;
        data_nxt_s  = data_r;
        lfsr_nxt_s  = lfsr_base_s;
        err_nxt_s   = err_base_s;
        if (!en) begin
            lfsr_nxt_s = {ECC_BITS{1'b0}};
            err_nxt_s  = 1'b0;
        end else if (parity) begin
            lfsr_nxt_s = {2'b00, lfsr_base_s[ECC_BITS-1:2]};
            err_nxt_s  = err_base_s | bch_mismatch2(lfsr_base_s, d1, d2);
        end else begin
            data_nxt_s = {d2, d1, data_r[SUB_DATA_BITS-1:2]};
            lfsr_nxt_s = bch_step(bch_step(lfsr_base_s, d1), d2);
            err_nxt_s  = err_base_s;
        end
    end

    // Lane state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_r <= {SUB_DATA_BITS{1'b0}};
            lfsr_r <= {ECC_BITS{1'b0}};
            err_r  <= 1'b0;
        end else begin
            data_r <= data_nxt_s;
            lfsr_r <= lfsr_nxt_s;
            err_r  <= err_nxt_s;
        end
    end

    assign data = data_r;
    assign err  = err_r;

endmodule

// File: rtl/hdmi_aux_unpacker.sv
// HDMI data-island aux unpacker: tracks the 32-period packet slot, rebuilds
// the 24-bit header and four 56-bit subpackets, checks BCH parity on each
// and publishes the packet with per-part error flags.
module hdmi_aux_unpacker
    import hdmi_aux_unpacker_pkg::*;
#(
    parameter string BYPASS_ECC = "FALSE"
) (
    input  logic                clk,
    input  logic                rst,
    hdmi_aux_unpacker_if.slave  aux
);

    localparam bit BYPASS = (BYPASS_ECC == "TRUE");

    logic                     ae_q;
    logic [3:0]               ch0_q;
    logic [3:0]               ch1_q;
    logic [3:0]               ch2_q;
    logic                     ch0_unused_s;

    logic [SLOT_W-1:0]        slot_r;
    logic                     done_r;
    aux_phase_e               phase_s;
    logic                     pkt_start_s;
    logic                     abort_s;

    logic [HDR_DATA_BITS-1:0] hdr_cap_r;
    logic [HDR_DATA_BITS-1:0] hdr_cap_nxt_s;
    logic [ECC_BITS-1:0]      hdr_lfsr_r;
    logic [ECC_BITS-1:0]      hdr_lfsr_base_s;
    logic [ECC_BITS-1:0]      hdr_lfsr_nxt_s;
    logic                     hdr_err_r;
    logic                     hdr_err_base_s;
    logic                     hdr_err_nxt_s;

    logic [SUB_DATA_BITS-1:0] sub_data_s [4];
    logic [3:0]               sub_err_s;

    // Channel 0 bit 3 carries nothing on the aux path.
    assign ch0_unused_s = ch0_q[3];

    // Input stage: everything downstream works on these registered copies.
    always_ff @(posedge clk) begin
        if (rst) begin
            ae_q  <= 1'b0;
            ch0_q <= 4'h0;
            ch1_q <= 4'h0;
            ch2_q <= 4'h0;
        end else begin
            ae_q  <= aux.ae;
            ch0_q <= aux.channel0_aux;
            ch1_q <= aux.channel1_aux;
            ch2_q <= aux.channel2_aux;
        end
    end

    // Slot counter (wraps for back-to-back packets) and end-of-packet flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_r <= {SLOT_W{1'b0}};
            done_r <= 1'b0;
        end else if (!ae_q) begin
            slot_r <= {SLOT_W{1'b0}};
            done_r <= 1'b0;
        end else begin
            slot_r <= slot_r + 5'd1;
            done_r <= (slot_r == LAST_SLOT);
        end
    end

    // Slot decode: phase, packet start and mid-packet ae drop.
    always_comb begin
        phase_s     = PH_IDLE;
        pkt_start_s = ae_q && (slot_r == {SLOT_W{1'b0}});
        abort_s     = !ae_q && (slot_r != {SLOT_W{1'b0}});
        if (!ae_q) begin
            phase_s = PH_IDLE;
        end else if (slot_r < HDR_PARITY_SLOT) begin
            phase_s = PH_DATA;
        end else if (slot_r < SUB_PARITY_SLOT) begin
            phase_s = PH_HDR_PARITY;
        end else begin
            phase_s = PH_ALL_PARITY;
        end
    end

    // Header capture and single-bit BCH check next-state.
    always_comb begin
        hdr_lfsr_base_s = pkt_start_s ? {ECC_BITS{1'b0}} : hdr_lfsr_r;
        hdr_err_base_s  = pkt_start_s ? 1'b0 : hdr_err_r;
        hdr_cap_nxt_s   = hdr_cap_r;
        hdr_lfsr_nxt_s  = hdr_lfsr_base_s;
        hdr_err_nxt_s   = hdr_err_base_s;
        case (phase_s)
            PH_IDLE: begin
                hdr_lfsr_nxt_s = {ECC_BITS{1'b0}};
                hdr_err_nxt_s  = 1'b0;
            end
            PH_DATA: begin
                hdr_cap_nxt_s  = {ch0_q[2], hdr_cap_r[HDR_DATA_BITS-1:1]};
                hdr_lfsr_nxt_s = bch_step(hdr_lfsr_base_s, ch0_q[2]);
            end
            PH_HDR_PARITY, PH_ALL_PARITY: begin
                hdr_lfsr_nxt_s = {1'b0, hdr_lfsr_base_s[ECC_BITS-1:1]};
                hdr_err_nxt_s  = hdr_err_base_s | (ch0_q[2] != hdr_lfsr_base_s[0]);
            end
            default: begin
                hdr_lfsr_nxt_s = {ECC_BITS{1'b0}};
                hdr_err_nxt_s  = 1'b0;
            end
        endcase
    end

    // Header state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            hdr_cap_r  <= {HDR_DATA_BITS{1'b0}};
            hdr_lfsr_r <= {ECC_BITS{1'b0}};
            hdr_err_r  <= 1'b0;
        end else begin
            hdr_cap_r  <= hdr_cap_nxt_s;
            hdr_lfsr_r <= hdr_lfsr_nxt_s;
            hdr_err_r  <= hdr_err_nxt_s;
        end
    end

    for (genvar n = 0; n < 4; n++) begin : g_sub
        hdmi_aux_unpacker_sub_capture u_sub (
            .clk    (clk),
            .rst    (rst),
            .en     (ae_q),
            .start  (pkt_start_s),
            .parity (phase_s == PH_ALL_PARITY),
            .d1     (ch1_q[n]),
            .d2     (ch2_q[n]),
            .data   (sub_data_s[n]),
            .err    (sub_err_s[n])
        );
    end

    // Output registers: sync passthrough, event pulses and packet publish.
    always_ff @(posedge clk) begin
        if (rst) begin
            aux.hsync_out    <= 1'b0;
            aux.vsync_out    <= 1'b0;
            aux.packet_valid <= 1'b0;
            aux.packet_abort <= 1'b0;
            aux.header       <= {HDR_DATA_BITS{1'b0}};
            aux.sub0         <= {SUB_DATA_BITS{1'b0}};
            aux.sub1         <= {SUB_DATA_BITS{1'b0}};
            aux.sub2         <= {SUB_DATA_BITS{1'b0}};
            aux.sub3         <= {SUB_DATA_BITS{1'b0}};
            aux.header_err   <= 1'b0;
            aux.sub_err      <= 4'b0000;
        end else begin
            aux.packet_valid <= done_r;
            aux.packet_abort <= abort_s;
            if (ae_q) begin
                aux.hsync_out <= ch0_q[0];
                aux.vsync_out <= ch0_q[1];
            end
            if (done_r) begin
                aux.header     <= hdr_cap_r;
                aux.sub0       <= sub_data_s[0];
                aux.sub1       <= sub_data_s[1];
                aux.sub2       <= sub_data_s[2];
                aux.sub3       <= sub_data_s[3];
                aux.header_err <= BYPASS ? 1'b0 : hdr_err_r;
                aux.sub_err    <= BYPASS ? 4'b0000 : sub_err_s;
            end
        end
    end

endmodule

// File: tb/tb_hdmi_aux_unpacker.sv
// Directed bench for hdmi_aux_unpacker: a checked DUT and an ECC-bypass DUT
// share one stimulus stream built by a small transmit-side packer model.
module tb_hdmi_aux_unpacker;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hdmi_aux_unpacker_if ifa();
    hdmi_aux_unpacker_if ifb();

    hdmi_aux_unpacker #(.BYPASS_ECC("FALSE")) u_dut (
        .clk (clk),
        .rst (rst),
        .aux (ifa)
    );

    hdmi_aux_unpacker #(.BYPASS_ECC("TRUE")) u_dut_byp (
        .clk (clk),
        .rst (rst),
        .aux (ifb)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int pv_a = 0;
    int ab_a = 0;
    int pv_b = 0;
    int last_pv_cyc = 0;
    int prev_pv_cyc = 0;
    logic [23:0] last_hdr = 24'h0;
    logic [23:0] prev_hdr = 24'h0;

    logic [3:0] s_c0 [32];
    logic [3:0] s_c1 [32];
    logic [3:0] s_c2 [32];

    localparam logic [23:0] AVI_HDR = 24'h0D0282;
    localparam logic [55:0] AVI_S0  = 56'h00112233445566;
    localparam logic [55:0] AVI_S1  = 56'hFEDCBA98765432;
    localparam logic [55:0] AVI_S2  = 56'h80000000000001;
    localparam logic [55:0] AVI_S3  = 56'hFFFFFFFFFFFFFF;
    localparam logic [23:0] B_HDR   = 24'h5A0184;
    localparam logic [55:0] B_S0    = 56'h0123456789ABCD;
    localparam logic [55:0] B_S2    = 56'h13579BDF02468A;

    // Cycle counter.
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (ifa.packet_valid) begin
            pv_a        = pv_a + 1;
            prev_pv_cyc = last_pv_cyc;
            last_pv_cyc = cyc;
            prev_hdr    = last_hdr;
            last_hdr    = ifa.header;
        end
        if (ifa.packet_abort) ab_a = ab_a + 1;
        if (ifb.packet_valid) pv_b = pv_b + 1;
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic ae, input logic [3:0] c0, input logic [3:0] c1, input logic [3:0] c2);
        ifa.ae = ae; ifa.channel0_aux = c0; ifa.channel1_aux = c1; ifa.channel2_aux = c2;
        ifb.ae = ae; ifb.channel0_aux = c0; ifb.channel1_aux = c1; ifb.channel2_aux = c2;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 4'h0, 4'h0, 4'h0);
    endtask

    // Textbook CRC remainder, first-sent bit = msg[0]; P_k is r[7-k].
    function automatic logic [7:0] bch_ref(input logic [63:0] msg, input int nbits);
        logic [7:0] r;
        logic       fb;
        r = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            fb = r[7] ^ msg[i];
            r  = {r[6:0], 1'b0} ^ (fb ? 8'hC1 : 8'h00);
        end
        return r;
    endfunction

    task automatic build_packet(input logic [23:0] hdr, input logic [55:0] s0, input logic [55:0] s1,
                                input logic [55:0] s2, input logic [55:0] s3, input logic hs, input logic vs);
        logic [7:0]  hp;
        logic [7:0]  sp [4];
        logic [55:0] sb [4];
        sb[0] = s0; sb[1] = s1; sb[2] = s2; sb[3] = s3;
        hp = bch_ref({40'h0, hdr}, 24);
        for (int n = 0; n < 4; n++) sp[n] = bch_ref({8'h0, sb[n]}, 56);
        for (int i = 0; i < 32; i++) begin
            s_c0[i][0] = hs;
            s_c0[i][1] = vs;
            s_c0[i][3] = i[0];
            if (i < 24) s_c0[i][2] = hdr[i];
            else        s_c0[i][2] = hp[7-(i-24)];
            for (int n = 0; n < 4; n++) begin
                if (i < 28) begin
                    s_c1[i][n] = sb[n][2*i];
                    s_c2[i][n] = sb[n][2*i+1];
                end else begin
                    s_c1[i][n] = sp[n][7-2*(i-28)];
                    s_c2[i][n] = sp[n][6-2*(i-28)];
                end
            end
        end
    endtask

    task automatic send_slots(input int nslots);
        for (int i = 0; i < nslots; i++) drive(1'b1, s_c0[i], s_c1[i], s_c2[i]);
    endtask

    initial begin
        int pv0;
        int ab0;
        int pvb0;
        int t0;

        // Reset
        rst = 1'b1;
        idle(3);
        check_val("rst_header", 64'(ifa.header), 64'h0);
        check_val("rst_sub0", 64'(ifa.sub0), 64'h0);
        check_val("rst_flags", 64'({ifa.packet_valid, ifa.packet_abort, ifa.header_err, ifa.sub_err}), 64'h0);
        check_val("rst_sync", 64'({ifa.hsync_out, ifa.vsync_out}), 64'h0);
        rst = 1'b0;
        idle(2);

        // Null packet, latency
        build_packet(24'h0, 56'h0, 56'h0, 56'h0, 56'h0, 1'b0, 1'b0);
        pv0 = pv_a; t0 = cyc;
        send_slots(32); idle(4);
        check_val("null_pv_count", 64'(pv_a - pv0), 64'd1);
        check_val("null_latency", 64'(last_pv_cyc - t0), 64'd34);
        check_val("null_header", 64'(ifa.header), 64'h0);
        check_val("null_subs", 64'(ifa.sub0 | ifa.sub1 | ifa.sub2 | ifa.sub3), 64'h0);
        check_val("null_errs", 64'({ifa.header_err, ifa.sub_err}), 64'h0);

        // AVI InfoFrame
        build_packet(AVI_HDR, AVI_S0, AVI_S1, AVI_S2, AVI_S3, 1'b1, 1'b0);
        send_slots(32); idle(4);
        check_val("avi_header", 64'(ifa.header), 64'(AVI_HDR));
        check_val("avi_sub0", 64'(ifa.sub0), 64'(AVI_S0));
        check_val("avi_sub1", 64'(ifa.sub1), 64'(AVI_S1));
        check_val("avi_sub2", 64'(ifa.sub2), 64'(AVI_S2));
        check_val("avi_sub3", 64'(ifa.sub3), 64'(AVI_S3));
        check_val("avi_errs", 64'({ifa.header_err, ifa.sub_err}), 64'h0);
        check_val("avi_sync_hold", 64'({ifa.vsync_out, ifa.hsync_out}), 64'h1);
        check_val("avi_byp_sub0", 64'(ifb.sub0), 64'(AVI_S0));

        // Header bit 5 flipped
        build_packet(AVI_HDR, AVI_S0, AVI_S1, AVI_S2, AVI_S3, 1'b1, 1'b0);
        s_c0[5][2] = ~s_c0[5][2];
        send_slots(32); idle(4);
        check_val("hflip_header", 64'(ifa.header), 64'h0D02A2);
        check_val("hflip_header_err", 64'(ifa.header_err), 64'h1);
        check_val("hflip_sub_err", 64'(ifa.sub_err), 64'h0);
        check_val("hflip_byp_err", 64'(ifb.header_err), 64'h0);

        // Ch2 bit 3 flipped in slot 30 (subpacket 3 parity)
        build_packet(AVI_HDR, AVI_S0, AVI_S1, AVI_S2, AVI_S3, 1'b1, 1'b0);
        s_c2[30][3] = ~s_c2[30][3];
        send_slots(32); idle(4);
        check_val("pflip_sub_err", 64'(ifa.sub_err), 64'h8);
        check_val("pflip_header_err", 64'(ifa.header_err), 64'h0);
        check_val("pflip_sub3", 64'(ifa.sub3), 64'(AVI_S3));
        check_val("pflip_byp_sub_err", 64'(ifb.sub_err), 64'h0);

        // Two packets back-to-back in one island
        pv0 = pv_a; ab0 = ab_a;
        build_packet(AVI_HDR, AVI_S0, AVI_S1, AVI_S2, AVI_S3, 1'b1, 1'b0);
        send_slots(32);
        build_packet(B_HDR, B_S0, AVI_S3, B_S2, AVI_S1, 1'b0, 1'b1);
        send_slots(32); idle(4);
        check_val("b2b_pv_count", 64'(pv_a - pv0), 64'd2);
        check_val("b2b_abort", 64'(ab_a - ab0), 64'd0);
        check_val("b2b_spacing", 64'(last_pv_cyc - prev_pv_cyc), 64'd32);
        check_val("b2b_first_hdr", 64'(prev_hdr), 64'(AVI_HDR));
        check_val("b2b_second_hdr", 64'(last_hdr), 64'(B_HDR));
        check_val("b2b_sub2", 64'(ifa.sub2), 64'(B_S2));
        check_val("b2b_errs", 64'({ifa.header_err, ifa.sub_err}), 64'h0);
        check_val("b2b_vsync", 64'({ifa.vsync_out, ifa.hsync_out}), 64'h2);

        // ae dropped at slot 17, then a clean packet
        pv0 = pv_a; ab0 = ab_a;
        build_packet(AVI_HDR, AVI_S0, AVI_S1, AVI_S2, AVI_S3, 1'b1, 1'b0);
        send_slots(17); idle(4);
        check_val("abort_count", 64'(ab_a - ab0), 64'd1);
        check_val("abort_no_pv", 64'(pv_a - pv0), 64'd0);
        build_packet(B_HDR, B_S0, AVI_S3, B_S2, AVI_S1, 1'b0, 1'b1);
        send_slots(32); idle(4);
        check_val("post_abort_pv", 64'(pv_a - pv0), 64'd1);
        check_val("post_abort_header", 64'(ifa.header), 64'(B_HDR));
        check_val("post_abort_sub0", 64'(ifa.sub0), 64'(B_S0));
        check_val("post_abort_errs", 64'({ifa.header_err, ifa.sub_err}), 64'h0);

        // All parity slots corrupted: checked DUT flags, bypass DUT does not
        pvb0 = pv_b;
        build_packet(AVI_HDR, AVI_S0, AVI_S1, AVI_S2, AVI_S3, 1'b1, 1'b0);
        for (int i = 24; i < 32; i++) s_c0[i][2] = ~s_c0[i][2];
        for (int i = 28; i < 32; i++) begin
            s_c1[i] = ~s_c1[i];
            s_c2[i] = ~s_c2[i];
        end
        send_slots(32); idle(4);
        check_val("allpar_header_err", 64'(ifa.header_err), 64'h1);
        check_val("allpar_sub_err", 64'(ifa.sub_err), 64'hF);
        check_val("byp_pv", 64'(pv_b - pvb0), 64'd1);
        check_val("byp_errs", 64'({ifb.header_err, ifb.sub_err}), 64'h0);
        check_val("byp_header", 64'(ifb.header), 64'(AVI_HDR));
        check_val("byp_sub1", 64'(ifb.sub1), 64'(AVI_S1));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
